// File: rtl/seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_decoder
//
// Receive-side monitor for the multiplexed 4-digit seven-segment display bus.
// It samples the bus on the 200 Hz scan clock and decodes each displayed
// digit into a per-slot shadow register. Once all four slots have been seen,
// it publishes a complete frame.
//
// Ports
//   clk_200        in   scan clock (same clock that advances the digit select)
//   rst            in   asynchronous, active-high reset
//   segments[6:0]  in   {a,b,c,d,e,f,g}, active low
//   anode_active   in   digit enables, active low, one-hot-low when legal
//   decimalPt      in   decimal point, active low
//   digits[15:0]   out  last committed frame, [15:12] = leftmost digit
//   dp_mask[3:0]   out  committed decimal points, bit 3 = leftmost, 1 = lit
//   err_mask[3:0]  out  committed per-digit illegal-pattern flags
//   frame_valid    out  one-cycle pulse when the committed outputs update
//   frame_changed  out  one-cycle pulse with frame_valid when digits changed
//   anode_err      out  one-cycle pulse on a multi-hot-low / all-on anode
//   stale          out  level, no frame completed within TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module seven_seg_scan_decoder #(
    parameter int TIMEOUT_CYCLES = 16   // legal range 4..255
) (
    input  logic        clk_200,
    input  logic        rst,
    input  logic [6:0]  segments,
    input  logic [3:0]  anode_active,
    input  logic        decimalPt,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic [3:0]  err_mask,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        anode_err,
    output logic        stale
);

    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_CYCLES);

    // Input stage (S0). It resets to the idle bus value: all anodes off,
    // all segments dark.
    logic [6:0]  seg_s0;
    logic [3:0]  anode_s0;
    logic        dp_n_s0;

    // Per-slot shadow of the frame under construction.
    logic [15:0] shadow_digits;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_err;
    logic [3:0]  seen;
    logic [7:0]  timeout_count;

    // Combinational decode of the S0 sample.
    logic        anode_legal;
    logic [1:0]  slot_idx;
    logic [3:0]  slot_bit;
    logic [3:0]  nibble;
    logic        pattern_err;
    logic [15:0] shadow_digits_next;
    logic [3:0]  shadow_dp_next;
    logic [3:0]  shadow_err_next;
    logic [3:0]  seen_next;
    logic        commit;

    // Anode decode: only a single low enable selects a slot.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        anode_legal = 1'b1;
        slot_idx    = 2'd0;
        slot_bit    = 4'b0000;
        unique case (anode_s0)
            4'b0111: begin slot_idx = 2'd3; slot_bit = 4'b1000; end
            4'b1011: begin slot_idx = 2'd2; slot_bit = 4'b0100; end
            4'b1101: begin slot_idx = 2'd1; slot_bit = 4'b0010; end
            4'b1110: begin slot_idx = 2'd0; slot_bit = 4'b0001; end
            default: anode_legal = 1'b0;
        endcase
    end

    // Segment pattern decode (active low, abcdefg). Blank decodes to F without
    // an error. Any other unknown pattern also decodes to F, but flags an error.
    always_comb begin
        nibble      = 4'hF;
        pattern_err = 1'b0;
        unique case (seg_s0)
            7'b0000001: nibble = 4'd0;
            7'b1001111: nibble = 4'd1;
            7'b0010010: nibble = 4'd2;
            7'b0000110: nibble = 4'd3;
            7'b1001100: nibble = 4'd4;
            7'b0100100: nibble = 4'd5;
            7'b0100000: nibble = 4'd6;
            7'b0001111: nibble = 4'd7;
            7'b0000000: nibble = 4'd8;
            7'b0000100: nibble = 4'd9;
            7'b1111111: nibble = 4'hF;
            default:    pattern_err = 1'b1;
        endcase
    end

    // The shadow as it will look after this edge. The commit path reads these
    // values, so the slot captured in the same cycle is forwarded straight
    // into the published frame.
    always_comb begin
        shadow_digits_next = shadow_digits;
        shadow_dp_next     = shadow_dp;
        shadow_err_next    = shadow_err;
        seen_next          = seen;
        if (anode_legal) begin
            shadow_digits_next[{slot_idx, 2'b00} +: 4] = nibble;
            shadow_dp_next[slot_idx]                   = ~dp_n_s0;
            shadow_err_next[slot_idx]                  = pattern_err;
            seen_next                                  = seen | slot_bit;
        end
    end

    assign commit = anode_legal && (seen_next == 4'b1111);

    // NOTE: the reset is asynchronous (it appears in the sensitivity list), so
    // a mid-frame rst discards the partial shadow at once, without waiting
    // for a clock edge.
    always_ff @(posedge clk_200 or posedge rst) begin
        if (rst) begin
            seg_s0        <= 7'b1111111;
            anode_s0      <= 4'b1111;
            dp_n_s0       <= 1'b1;
            shadow_digits <= 16'h0000;
            shadow_dp     <= 4'h0;
            shadow_err    <= 4'h0;
            seen          <= 4'b0000;
            timeout_count <= TIMEOUT_MAX;
            digits        <= 16'h0000;
            dp_mask       <= 4'h0;
            err_mask      <= 4'h0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            anode_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every right-hand side
            // reads the pre-edge value, so statement order cannot matter.
            seg_s0        <= segments;
            anode_s0      <= anode_active;
            dp_n_s0       <= decimalPt;

            shadow_digits <= shadow_digits_next;
            shadow_dp     <= shadow_dp_next;
            shadow_err    <= shadow_err_next;
            seen          <= commit ? 4'b0000 : seen_next;

            frame_valid   <= commit;
            frame_changed <= commit && (shadow_digits_next != digits);
            anode_err     <= !anode_legal && (anode_s0 != 4'b1111);

            if (commit) begin
                digits   <= shadow_digits_next;
                dp_mask  <= shadow_dp_next;
                err_mask <= shadow_err_next;
            end

            // A commit always wins over saturation.
            if (commit) begin
                timeout_count <= 8'd0;
            end else if (timeout_count != TIMEOUT_MAX) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end

    assign stale = (timeout_count == TIMEOUT_MAX);

endmodule
